// File: rtl/axi_arb_pkg.sv
// Shared types for the two-requester AXI4-Lite port arbiter.
package axi_arb_pkg;

  typedef enum logic [1:0] {R_IDLE, R_ADDR, R_DATA} rd_state_t;
  typedef enum logic [1:0] {W_IDLE, W_SEND, W_RESP} wr_state_t;
  typedef enum logic {GNT_I = 1'b0, GNT_D = 1'b1} grant_t;

  localparam logic [1:0] AXI_RESP_OKAY = 2'b00;

endpackage

// File: rtl/axi_port_arbiter_if.sv
// Requester (fetch / dcache) and AXI master-port signals seen by the arbiter.
interface axi_port_arbiter_if #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32,
  parameter int STRB_W = DATA_W / 8
) ();

  logic [ADDR_W-1:0] i_araddr;
  logic              i_arvalid, i_arready;
  logic [DATA_W-1:0] i_rdata;
  logic              i_rvalid, i_rready;

  logic [ADDR_W-1:0] d_araddr;
  logic              d_arvalid, d_arready;
  logic [DATA_W-1:0] d_rdata;
  logic              d_rvalid, d_rready;
  logic [ADDR_W-1:0] d_awaddr;
  logic              d_awvalid, d_awready;
  logic [DATA_W-1:0] d_wdata;
  logic [STRB_W-1:0] d_wstrb;
  logic              d_wvalid, d_wready;
  logic [1:0]        d_bresp;
  logic              d_bvalid, d_bready;

  logic [ADDR_W-1:0] m_araddr;
  logic              m_arvalid, m_arready;
  logic [DATA_W-1:0] m_rdata;
  logic              m_rvalid, m_rready;
  logic [ADDR_W-1:0] m_awaddr;
  logic              m_awvalid, m_awready;
  logic [DATA_W-1:0] m_wdata;
  logic [STRB_W-1:0] m_wstrb;
  logic              m_wvalid, m_wready;
  logic [1:0]        m_bresp;
  logic              m_bvalid, m_bready;

  // Arbiter view.
  modport slave (
    input  i_araddr, i_arvalid, i_rready,
    output i_arready, i_rdata, i_rvalid,
    input  d_araddr, d_arvalid, d_rready, d_awaddr, d_awvalid, d_wdata, d_wstrb, d_wvalid, d_bready,
    output d_arready, d_rdata, d_rvalid, d_awready, d_wready, d_bresp, d_bvalid,
    output m_araddr, m_arvalid, m_rready, m_awaddr, m_awvalid, m_wdata, m_wstrb, m_wvalid, m_bready,
    input  m_arready, m_rdata, m_rvalid, m_awready, m_wready, m_bresp, m_bvalid
  );

  // Environment view: requesters plus AXI slave.
  modport master (
    output i_araddr, i_arvalid, i_rready,
    input  i_arready, i_rdata, i_rvalid,
    output d_araddr, d_arvalid, d_rready, d_awaddr, d_awvalid, d_wdata, d_wstrb, d_wvalid, d_bready,
    input  d_arready, d_rdata, d_rvalid, d_awready, d_wready, d_bresp, d_bvalid,
    input  m_araddr, m_arvalid, m_rready, m_awaddr, m_awvalid, m_wdata, m_wstrb, m_wvalid, m_bready,
    output m_arready, m_rdata, m_rvalid, m_awready, m_wready, m_bresp, m_bvalid
  );

endinterface

// File: rtl/axi_port_arbiter_rr_arb2.sv
// Two-way round-robin selector; remembers the last requester served.
module rr_arb2
  import axi_arb_pkg::*;
(
  input  logic   clk,
  input  logic   rst,
  input  logic   req_i,
  input  logic   req_d,
  input  logic   upd,
  input  grant_t upd_gnt,
  output grant_t win
);

  grant_t last_grant_q, last_grant_d;

  always_comb begin
    last_grant_d = last_grant_q;
    if (upd) last_grant_d = upd_gnt;
    if (req_i && req_d) win = (last_grant_q == GNT_I) ? GNT_D : GNT_I;
    else if (req_d)     win = GNT_D;
    else                win = GNT_I;
  end

  always_ff @(posedge clk) begin
    if (!rst) last_grant_q <= GNT_I;
    else      last_grant_q <= last_grant_d;
  end

endmodule

// File: rtl/axi_port_arbiter.sv
// Shares one AXI4-Lite master port between fetch (read) and dcache (read/write);
// reads are serialised round-robin, dcache writes run on their own FSM.
module axi_port_arbiter
  import axi_arb_pkg::*;
#(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32,
  parameter int STRB_W = DATA_W / 8
) (
  input logic clk,
  input logic rst,
  axi_port_arbiter_if.slave bus
);

  rd_state_t         rd_state_q, rd_state_d;
  wr_state_t         wr_state_q, wr_state_d;
  grant_t            gnt_q, gnt_d, win;
  logic [ADDR_W-1:0] m_araddr_q, m_araddr_d, m_awaddr_q, m_awaddr_d;
  logic [DATA_W-1:0] m_wdata_q, m_wdata_d;
  logic [STRB_W-1:0] m_wstrb_q, m_wstrb_d;
  logic              m_arvalid_q, m_arvalid_d, m_awvalid_q, m_awvalid_d, m_wvalid_q, m_wvalid_d;
  logic              d_req, arb_upd, rready_sel, aw_done, w_done;

  // Holding off D reads while any D write is pending keeps writes ordered first.
  assign d_req = bus.d_arvalid & ~bus.d_awvalid & (wr_state_q == W_IDLE);

  rr_arb2 u_rr_arb2 (
    .clk    (clk),
    .rst    (rst),
    .req_i  (bus.i_arvalid),
    .req_d  (d_req),
    .upd    (arb_upd),
    .upd_gnt(gnt_q),
    .win    (win)
  );

  always_comb begin
    rd_state_d    = rd_state_q;
    gnt_d         = gnt_q;
    m_araddr_d    = m_araddr_q;
    m_arvalid_d   = m_arvalid_q;
    arb_upd       = 1'b0;
    rready_sel    = 1'b0;
    bus.i_arready = 1'b0;
    bus.d_arready = 1'b0;
    bus.i_rvalid  = 1'b0;
    bus.d_rvalid  = 1'b0;
    bus.i_rdata   = '0;
    bus.d_rdata   = '0;
    bus.m_rready  = 1'b0;
    case (rd_state_q)
      R_IDLE: begin
        if (rst && (bus.i_arvalid || d_req)) begin
          gnt_d       = win;
          m_arvalid_d = 1'b1;
          rd_state_d  = R_ADDR;
          if (win == GNT_D) begin
            bus.d_arready = 1'b1;
            m_araddr_d    = bus.d_araddr;
          end else begin
            bus.i_arready = 1'b1;
            m_araddr_d    = bus.i_araddr;
          end
        end
      end
      R_ADDR: begin
        if (bus.m_arready) begin
          m_arvalid_d = 1'b0;
          rd_state_d  = R_DATA;
        end
      end
      R_DATA: begin
        if (gnt_q == GNT_D) begin
          rready_sel   = bus.d_rready;
          bus.d_rvalid = bus.m_rvalid;
          bus.d_rdata  = bus.m_rdata;
        end else begin
          rready_sel   = bus.i_rready;
          bus.i_rvalid = bus.m_rvalid;
          bus.i_rdata  = bus.m_rdata;
        end
        bus.m_rready = rready_sel;
        if (bus.m_rvalid && rready_sel) begin
          arb_upd    = 1'b1;
          rd_state_d = R_IDLE;
        end
      end
      default: rd_state_d = R_IDLE;
    endcase
  end

  always_comb begin
    wr_state_d    = wr_state_q;
    m_awaddr_d    = m_awaddr_q;
    m_wdata_d     = m_wdata_q;
    m_wstrb_d     = m_wstrb_q;
    m_awvalid_d   = m_awvalid_q;
    m_wvalid_d    = m_wvalid_q;
    aw_done       = 1'b0;
    w_done        = 1'b0;
    bus.d_awready = 1'b0;
    bus.d_wready  = 1'b0;
    bus.d_bvalid  = 1'b0;
    bus.d_bresp   = AXI_RESP_OKAY;
    bus.m_bready  = 1'b0;
    case (wr_state_q)
      W_IDLE: begin
        if (rst && bus.d_awvalid && bus.d_wvalid && !(rd_state_q != R_IDLE && gnt_q == GNT_D)) begin
          bus.d_awready = 1'b1;
          bus.d_wready  = 1'b1;
          m_awaddr_d    = bus.d_awaddr;
          m_wdata_d     = bus.d_wdata;
          m_wstrb_d     = bus.d_wstrb;
          m_awvalid_d   = 1'b1;
          m_wvalid_d    = 1'b1;
          wr_state_d    = W_SEND;
        end
      end
      W_SEND: begin
        // A channel counts as done if it already handshook or does so this cycle.
        aw_done = !m_awvalid_q || bus.m_awready;
        w_done  = !m_wvalid_q || bus.m_wready;
        if (m_awvalid_q && bus.m_awready) m_awvalid_d = 1'b0;
        if (m_wvalid_q && bus.m_wready)   m_wvalid_d  = 1'b0;
        if (aw_done && w_done) wr_state_d = W_RESP;
      end
      W_RESP: begin
        bus.m_bready = bus.d_bready;
        bus.d_bvalid = bus.m_bvalid;
        bus.d_bresp  = bus.m_bresp;
        if (bus.m_bvalid && bus.d_bready) wr_state_d = W_IDLE;
      end
      default: wr_state_d = W_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      rd_state_q  <= R_IDLE;
      wr_state_q  <= W_IDLE;
      gnt_q       <= GNT_I;
      m_araddr_q  <= '0;
      m_arvalid_q <= 1'b0;
      m_awaddr_q  <= '0;
      m_wdata_q   <= '0;
      m_wstrb_q   <= '0;
      m_awvalid_q <= 1'b0;
      m_wvalid_q  <= 1'b0;
    end else begin
      rd_state_q  <= rd_state_d;
      wr_state_q  <= wr_state_d;
      gnt_q       <= gnt_d;
      m_araddr_q  <= m_araddr_d;
      m_arvalid_q <= m_arvalid_d;
      m_awaddr_q  <= m_awaddr_d;
      m_wdata_q   <= m_wdata_d;
      m_wstrb_q   <= m_wstrb_d;
      m_awvalid_q <= m_awvalid_d;
      m_wvalid_q  <= m_wvalid_d;
    end
  end

  assign bus.m_araddr  = m_araddr_q;
  assign bus.m_arvalid = m_arvalid_q;
  assign bus.m_awaddr  = m_awaddr_q;
  assign bus.m_wdata   = m_wdata_q;
  assign bus.m_wstrb   = m_wstrb_q;
  assign bus.m_awvalid = m_awvalid_q;
  assign bus.m_wvalid  = m_wvalid_q;

endmodule

// File: tb/tb_axi_port_arbiter.sv
// Directed bench for axi_port_arbiter; the bench plays both requesters and the AXI slave.
module tb_axi_port_arbiter;

  logic clk = 1'b0;
  logic rst = 1'b0;
  int unsigned n_total = 0;
  int unsigned n_pass  = 0;

  always #5 clk = ~clk;

  axi_port_arbiter_if #(.ADDR_W(32), .DATA_W(32), .STRB_W(4)) bus ();

  axi_port_arbiter #(.ADDR_W(32), .DATA_W(32), .STRB_W(4)) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  task automatic cyc(input int unsigned n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Completes an R_ADDR/R_DATA pair for whichever requester is granted.
  task automatic finish_read(input logic [31:0] data);
    bus.m_arready = 1'b1;
    cyc(1);
    bus.m_arready = 1'b0;
    bus.m_rdata   = data;
    bus.m_rvalid  = 1'b1;
    bus.i_rready  = 1'b1;
    bus.d_rready  = 1'b1;
    #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: observed timeout expected completion");
    $fatal(1);
  end

  initial begin
    logic [31:0] cont_addr [4];
    cont_addr = '{32'hB0, 32'hA0, 32'hB0, 32'hA0};

    bus.i_araddr = '0; bus.i_arvalid = 0; bus.i_rready = 0;
    bus.d_araddr = '0; bus.d_arvalid = 0; bus.d_rready = 0;
    bus.d_awaddr = '0; bus.d_awvalid = 0; bus.d_wdata = '0; bus.d_wstrb = '0;
    bus.d_wvalid = 0;  bus.d_bready = 0;
    bus.m_arready = 0; bus.m_rdata = '0; bus.m_rvalid = 0;
    bus.m_awready = 0; bus.m_wready = 0; bus.m_bresp = '0; bus.m_bvalid = 0;

    // Reset state
    cyc(2);
    chk("rst_m_arvalid", bus.m_arvalid, 0);
    chk("rst_m_awvalid", bus.m_awvalid, 0);
    chk("rst_m_wvalid",  bus.m_wvalid, 0);
    chk("rst_m_rready",  bus.m_rready, 0);
    chk("rst_m_bready",  bus.m_bready, 0);
    chk("rst_d_bvalid",  bus.d_bvalid, 0);
    chk("rst_m_araddr",  bus.m_araddr, 0);
    chk("rst_m_awaddr",  bus.m_awaddr, 0);
    chk("rst_m_wdata",   bus.m_wdata, 0);

    // Contention held from reset: D, I, D, I
    bus.i_araddr = 32'hA0; bus.i_arvalid = 1;
    bus.d_araddr = 32'hB0; bus.d_arvalid = 1;
    rst = 1'b1;
    #1;
    for (int k = 0; k < 4; k++) begin
      chk("cont_i_arready", bus.i_arready, (k % 2 == 1));
      chk("cont_d_arready", bus.d_arready, (k % 2 == 0));
      cyc(1);
      chk("cont_m_arvalid", bus.m_arvalid, 1);
      chk("cont_m_araddr", bus.m_araddr, cont_addr[k]);
      finish_read(32'h1000 + k);
      chk("cont_i_rvalid", bus.i_rvalid, (k % 2 == 1));
      chk("cont_d_rvalid", bus.d_rvalid, (k % 2 == 0));
      cyc(1);
      bus.m_rvalid = 0;
      if (k == 3) begin bus.i_arvalid = 0; bus.d_arvalid = 0; end
      #1;
    end
    bus.i_rready = 0; bus.d_rready = 0;

    // Stray m_rvalid in R_IDLE is ignored
    bus.m_rvalid = 1; bus.i_rready = 1; bus.d_rready = 1; #1;
    chk("stray_i_rvalid", bus.i_rvalid, 0);
    chk("stray_d_rvalid", bus.d_rvalid, 0);
    chk("stray_m_rready", bus.m_rready, 0);
    cyc(1);
    bus.m_rvalid = 0; bus.i_rready = 0; bus.d_rready = 0;

    // I-only read
    bus.i_araddr = 32'h8000_0000; bus.i_arvalid = 1; #1;
    chk("i1_i_arready", bus.i_arready, 1);
    chk("i1_d_arready", bus.d_arready, 0);
    chk("i1_arvalid_c0", bus.m_arvalid, 0);
    cyc(1);
    bus.i_arvalid = 0;
    chk("i1_arvalid_c1", bus.m_arvalid, 1);
    chk("i1_m_araddr", bus.m_araddr, 32'h8000_0000);
    finish_read(32'h0000_0013);
    chk("i1_i_rvalid", bus.i_rvalid, 1);
    chk("i1_i_rdata", bus.i_rdata, 32'h13);
    chk("i1_d_rvalid", bus.d_rvalid, 0);
    chk("i1_m_rready", bus.m_rready, 1);
    cyc(1);
    bus.m_rvalid = 0; bus.i_rready = 0; bus.d_rready = 0; #1;
    chk("i1_i_rvalid_done", bus.i_rvalid, 0);

    // Backpressure: i_rready low for 4 cycles in R_DATA, D read waiting
    bus.i_araddr = 32'h100; bus.i_arvalid = 1;
    cyc(1);
    bus.i_arvalid = 0; bus.m_arready = 1;
    cyc(1);
    bus.m_arready = 0; bus.m_rvalid = 1; bus.m_rdata = 32'h55;
    bus.d_araddr = 32'h200; bus.d_arvalid = 1;
    for (int k = 0; k < 4; k++) begin
      #1;
      chk("bp_m_rready", bus.m_rready, 0);
      chk("bp_d_arready", bus.d_arready, 0);
      chk("bp_i_rvalid", bus.i_rvalid, 1);
      cyc(1);
    end
    bus.i_rready = 1; #1;
    chk("bp_m_rready_go", bus.m_rready, 1);
    chk("bp_i_rdata", bus.i_rdata, 32'h55);
    cyc(1);
    bus.m_rvalid = 0; bus.i_rready = 0; #1;
    chk("bp_d_arready_next", bus.d_arready, 1);
    cyc(1);
    bus.d_arvalid = 0;
    chk("bp_d_m_araddr", bus.m_araddr, 32'h200);
    finish_read(32'h77);
    chk("bp_d_rvalid", bus.d_rvalid, 1);
    chk("bp_d_rdata", bus.d_rdata, 32'h77);
    chk("bp_i_rvalid_off", bus.i_rvalid, 0);
    cyc(1);
    bus.m_rvalid = 0; bus.i_rready = 0; bus.d_rready = 0;

    // D write alone, awready delayed, wready immediate
    bus.d_awaddr = 32'h8000_1000; bus.d_wdata = 32'hDEAD_BEEF; bus.d_wstrb = 4'hF;
    bus.d_awvalid = 1; bus.d_wvalid = 1; #1;
    chk("w_d_awready", bus.d_awready, 1);
    chk("w_d_wready", bus.d_wready, 1);
    cyc(1);
    bus.d_awvalid = 0; bus.d_wvalid = 0;
    chk("w_c1_awvalid", bus.m_awvalid, 1);
    chk("w_c1_wvalid", bus.m_wvalid, 1);
    chk("w_m_awaddr", bus.m_awaddr, 32'h8000_1000);
    chk("w_m_wdata", bus.m_wdata, 32'hDEAD_BEEF);
    chk("w_m_wstrb", bus.m_wstrb, 4'hF);
    bus.m_wready = 1;
    cyc(1);
    bus.m_wready = 0;
    chk("w_c2_wvalid", bus.m_wvalid, 0);
    chk("w_c2_awvalid", bus.m_awvalid, 1);
    cyc(1);
    chk("w_c3_awvalid", bus.m_awvalid, 1);
    chk("w_c3_d_bvalid", bus.d_bvalid, 0);
    bus.m_awready = 1;
    cyc(1);
    bus.m_awready = 0;
    chk("w_c4_awvalid", bus.m_awvalid, 0);
    bus.d_bready = 1; bus.m_bresp = 2'b00; bus.m_bvalid = 1; #1;
    chk("w_m_bready", bus.m_bready, 1);
    chk("w_d_bvalid", bus.d_bvalid, 1);
    chk("w_d_bresp", bus.d_bresp, 2'b00);
    cyc(1);
    bus.m_bvalid = 0; #1;
    chk("w_d_bvalid_done", bus.d_bvalid, 0);
    chk("w_m_bready_done", bus.m_bready, 0);
    bus.d_bready = 0;

    // Write/read ordering: write first, I read overlaps, D read after response
    bus.d_awaddr = 32'h300; bus.d_wdata = 32'h1234_5678; bus.d_wstrb = 4'h3;
    bus.d_awvalid = 1; bus.d_wvalid = 1;
    bus.d_araddr = 32'h400; bus.d_arvalid = 1; #1;
    chk("ord_d_awready", bus.d_awready, 1);
    chk("ord_d_arready", bus.d_arready, 0);
    cyc(1);
    bus.d_awvalid = 0; bus.d_wvalid = 0;
    bus.i_araddr = 32'h500; bus.i_arvalid = 1;
    bus.m_awready = 1; bus.m_wready = 1; #1;
    chk("ord_i_arready", bus.i_arready, 1);
    chk("ord_d_arready_send", bus.d_arready, 0);
    chk("ord_m_wstrb", bus.m_wstrb, 4'h3);
    cyc(1);
    bus.i_arvalid = 0; bus.m_awready = 0; bus.m_wready = 0;
    chk("ord_m_araddr_i", bus.m_araddr, 32'h500);
    chk("ord_m_awvalid", bus.m_awvalid, 0);
    finish_read(32'h99);
    chk("ord_i_rdata", bus.i_rdata, 32'h99);
    chk("ord_d_arready_rdata", bus.d_arready, 0);
    cyc(1);
    bus.m_rvalid = 0; bus.i_rready = 0; bus.d_rready = 0; #1;
    chk("ord_d_arready_resp", bus.d_arready, 0);
    bus.m_bvalid = 1; bus.m_bresp = 2'b10; bus.d_bready = 1; #1;
    chk("ord_d_bresp", bus.d_bresp, 2'b10);
    chk("ord_d_bvalid", bus.d_bvalid, 1);
    chk("ord_d_arready_b", bus.d_arready, 0);
    cyc(1);
    bus.m_bvalid = 0; bus.m_bresp = 2'b00; bus.d_bready = 0; #1;
    chk("ord_d_arready_free", bus.d_arready, 1);
    cyc(1);
    bus.d_arvalid = 0;
    chk("ord_m_araddr_d", bus.m_araddr, 32'h400);
    finish_read(32'h42);
    chk("ord_d_rdata", bus.d_rdata, 32'h42);
    cyc(1);
    bus.m_rvalid = 0; bus.i_rready = 0; bus.d_rready = 0;

    // Reset while in R_DATA
    bus.i_araddr = 32'h600; bus.i_arvalid = 1;
    cyc(1);
    bus.i_arvalid = 0; bus.m_arready = 1;
    cyc(1);
    bus.m_arready = 0; bus.m_rvalid = 1; bus.m_rdata = 32'hBAD; #1;
    chk("rmid_i_rvalid_pre", bus.i_rvalid, 1);
    rst = 1'b0; bus.i_rready = 1;
    cyc(1);
    bus.m_rvalid = 0; #1;
    chk("rmid_m_arvalid", bus.m_arvalid, 0);
    chk("rmid_m_rready", bus.m_rready, 0);
    chk("rmid_i_rvalid", bus.i_rvalid, 0);
    chk("rmid_d_rvalid", bus.d_rvalid, 0);
    chk("rmid_m_awvalid", bus.m_awvalid, 0);
    chk("rmid_m_bready", bus.m_bready, 0);
    rst = 1'b1; bus.i_rready = 0;
    cyc(1);
    bus.i_araddr = 32'h700; bus.i_arvalid = 1; #1;
    chk("rpost_i_arready", bus.i_arready, 1);
    cyc(1);
    bus.i_arvalid = 0;
    chk("rpost_m_araddr", bus.m_araddr, 32'h700);
    finish_read(32'h1234);
    chk("rpost_i_rvalid", bus.i_rvalid, 1);
    chk("rpost_i_rdata", bus.i_rdata, 32'h1234);
    cyc(1);
    bus.m_rvalid = 0; bus.i_rready = 0; bus.d_rready = 0;
    cyc(1);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/axi_port_arbiter.md
Name: axi_port_arbiter

Overview:
- Shares the single AXI4-Lite master port of the core between two requesters: instruction fetch (I, read-only) and data cache (D, read and write).
- Serializes reads: one read outstanding at a time, with round-robin grant.
- Runs D writes on an independent write FSM, so an I read may overlap a D write.
- Sits between the PC/fetch logic, the data cache and the top-level AXI ports.

Parameters:
- ADDR_W, 32, address width of all ports.
- DATA_W, 32, data width of all ports.
- STRB_W, DATA_W/8, write-strobe width.

Ports:
- clk  in  1  core clock
- rst  in  1  synchronous reset, active-low (asserted when 0, sampled on rising clk)
- i_araddr  in  ADDR_W  fetch read address
- i_arvalid  in  1  fetch read request
- i_arready  out  1  fetch request accepted
- i_rdata  out  DATA_W  fetch read data
- i_rvalid  out  1  fetch data valid
- i_rready  in  1  fetch ready for data
- d_araddr  in  ADDR_W  dcache read address
- d_arvalid  in  1  dcache read request
- d_arready  out  1  dcache read request accepted
- d_rdata  out  DATA_W  dcache read data
- d_rvalid  out  1  dcache read data valid
- d_rready  in  1  dcache ready for read data
- d_awaddr  in  ADDR_W  dcache write address
- d_awvalid  in  1  dcache write address valid
- d_awready  out  1  dcache write address accepted
- d_wdata  in  DATA_W  dcache write data
- d_wstrb  in  STRB_W  dcache write strobes
- d_wvalid  in  1  dcache write data valid
- d_wready  out  1  dcache write data accepted
- d_bresp  out  2  write response to dcache
- d_bvalid  out  1  write response valid
- d_bready  in  1  dcache ready for response
- m_araddr  out  ADDR_W  AXI read address
- m_arvalid  out  1  AXI read address valid
- m_arready  in  1  AXI read address ready
- m_rdata  in  DATA_W  AXI read data
- m_rvalid  in  1  AXI read data valid
- m_rready  out  1  AXI ready for read data
- m_awaddr  out  ADDR_W  AXI write address
- m_awvalid  out  1  AXI write address valid
- m_awready  in  1  AXI write address ready
- m_wdata  out  DATA_W  AXI write data
- m_wstrb  out  STRB_W  AXI write strobes
- m_wvalid  out  1  AXI write data valid
- m_wready  in  1  AXI write data ready
- m_bresp  in  2  AXI write response
- m_bvalid  in  1  AXI write response valid
- m_bready  out  1  AXI ready for write response

Behaviour:

Reset:
- rd_state=R_IDLE, wr_state=W_IDLE, last_grant=I.
- All valid/ready outputs 0; latched address, data and strobe registers 0.

Read FSM, states R_IDLE, R_ADDR, R_DATA; grant register gnt∈{I,D}:
- d_req = d_arvalid & ~d_awvalid & (wr_state==W_IDLE), so writes are ordered before D reads.
- R_IDLE, arbitration: if only one of i_arvalid/d_req is set, that requester wins. If both are set, the requester other than last_grant wins.
- R_IDLE, acceptance: the winner's arready=1 combinationally that cycle. Its address is latched into m_araddr, gnt is set and the FSM goes to R_ADDR.
- R_ADDR: m_arvalid=1 (registered), held with address stable until m_arready=1, then go to R_DATA.
- R_DATA: m_rready = granted requester's rready. The granted requester's rvalid = m_rvalid and its rdata = m_rdata. The other requester's rvalid=0.
- R_DATA exit: on m_rvalid & m_rready, last_grant←gnt and go to R_IDLE.
- Latency: request at cycle 0 gives m_arvalid at cycle 1; the earliest data return to the requester is cycle 2.
- Back-to-back requests: in the cycle the FSM returns to R_IDLE, a pending request is arbitrated immediately.

Write FSM, states W_IDLE, W_SEND, W_RESP:
- W_IDLE: accepts only when d_awvalid & d_wvalid & ~(rd_state!=R_IDLE & gnt==D). Then d_awready=d_wready=1 for that cycle; address, data and strobes are latched; go to W_SEND.
- W_SEND: m_awvalid and m_wvalid both rise together. Each drops independently on its own handshake. Go to W_RESP when both are done, including the cycle the second completes.
- W_RESP: m_bready=d_bready, d_bvalid=m_bvalid, d_bresp=m_bresp. On m_bvalid & m_bready go to W_IDLE.

Boundary conditions:
- I read and D write proceed concurrently.
- D read and D write arriving in the same cycle: the write wins.
- A requester that drops arvalid before acceptance is ignored.
- Reset mid-transaction abandons it. The AXI slave is reset on the same rst, so no orphan responses occur.
- Any m_rvalid outside R_DATA is ignored; m_rready stays 0.

Decomposition:
- Shared package axi_arb_pkg: rd_state_t, wr_state_t, grant_t (GNT_I=0, GNT_D=1), AXI_RESP_OKAY=2'b00.
- One sub-module: rr_arb2, a 2-way round-robin selector holding the last_grant register.

Test Plan:
- I-only read: i_arvalid with i_araddr=0x8000_0000 at cycle 0 → m_arvalid=1 at cycle 1 with m_araddr=0x8000_0000. Slave returns 0x0000_0013 → i_rvalid=1, i_rdata=0x13, d_rvalid=0.
- Contention: i_arvalid and d_arvalid both held from reset → grant order D, I, D, I (m_araddr alternates between the two addresses) over four reads.
- D write alone: awaddr=0x8000_1000, wdata=0xDEAD_BEEF, wstrb=0xF. Slave awready delayed 3 cycles, wready immediate → m_wvalid drops after 1 cycle, m_awvalid after 3. bresp=0 is then forwarded with d_bvalid.
- Write/read ordering: d_awvalid, d_wvalid and d_arvalid in the same cycle → write handshake first. D read is granted only after d_bvalid & d_bready; an I read issued meanwhile completes during the write.
- Reset mid-read: rst=0 while in R_DATA → next cycle all m_* valid/ready and i/d valid outputs are 0. After release, a fresh I read completes normally.
- Backpressure: i_rready=0 for 4 cycles during R_DATA → m_rready stays 0, the FSM remains in R_DATA, and d requests are not accepted until the beat completes.
